// File: rtl/axi_arb_pkg.sv
// Shared types and default widths for the AXI write arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_DATA,
        ARB_RESP
    } arb_state_e;

    localparam int DEF_ADDR_W = 34;
    localparam int DEF_LEN_W  = 8;
    localparam int DEF_DATA_W = 512;

    // Client index width; a single client still gets a 1-bit id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
module rr_priority_pick
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_rot;
    int                 w_sum;

    // Rotate so that bit 0 of w_rot is the client at the pointer.
    assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        w_sum = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_any && w_rot[k]) begin
                o_any = 1'b1;
                w_sum = int'(i_ptr) + k;
                if (w_sum >= NUM_REQ) begin
                    w_sum = w_sum - NUM_REQ;
                end
                o_idx = ID_W'(w_sum);
            end
        end
        o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/axi_write_arbiter.sv
// Round-robin, whole-transaction arbiter sharing one AXI write master among NUM_REQ clients.
// A grant is held from request acceptance until the client has taken its B response.
module axi_write_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                         core_clk,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_start_address,
    input  logic [NUM_REQ*LEN_W-1:0]     req_len,
    output logic [NUM_REQ-1:0]           data_queue_pop,
    input  logic [NUM_REQ-1:0]           data_queue_data_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    data_queue_data,
    output logic [NUM_REQ-1:0]           resp_valid,
    input  logic [NUM_REQ-1:0]           resp_ready,
    output logic                         m_req_valid,
    input  logic                         m_req_ready,
    output logic [ADDR_W-1:0]            m_req_start_address,
    output logic [LEN_W-1:0]             m_req_len,
    input  logic                         m_data_queue_pop,
    output logic                         m_data_queue_data_valid,
    output logic [DATA_W-1:0]            m_data_queue_data,
    input  logic                         m_resp_valid,
    output logic                         m_resp_ready,
    output logic [id_width(NUM_REQ)-1:0] grant_id,
    output logic                         busy,
    output logic                         err_unexp_resp
);

    localparam int ID_W = id_width(NUM_REQ);

    arb_state_e         r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_grant_id;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_len;
    logic               r_err;

    logic [NUM_REQ-1:0] w_pick_grant;
    logic [ID_W-1:0]    w_pick_idx;
    logic               w_pick_any;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [ADDR_W-1:0]  w_pick_addr;
    logic [LEN_W-1:0]   w_pick_len;
    logic               w_grant_dvalid;
    logic               w_grant_resp_ready;
    logic [DATA_W-1:0]  w_grant_data;
    logic [ID_W-1:0]    w_next_ptr;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_grant_oh = NUM_REQ'(1) << r_grant_id;
    assign w_next_ptr = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

    // Payload of the pick candidate and signals of the current grantee.
    always_comb begin
        w_pick_addr        = '0;
        w_pick_len         = '0;
        w_grant_dvalid     = 1'b0;
        w_grant_data       = '0;
        w_grant_resp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_grant[i]) begin
                w_pick_addr = req_start_address[i*ADDR_W +: ADDR_W];
                w_pick_len  = req_len[i*LEN_W +: LEN_W];
            end
            if (w_grant_oh[i]) begin
                w_grant_dvalid     = data_queue_data_valid[i];
                w_grant_data       = data_queue_data[i*DATA_W +: DATA_W];
                w_grant_resp_ready = resp_ready[i];
            end
        end
    end

    // req_ready is gated by resetn so that no client sees an acceptance while held in reset.
    assign req_ready               = ((r_state == ARB_IDLE) && resetn) ? w_pick_grant : '0;
    assign m_req_valid             = (r_state == ARB_REQ);
    assign m_req_start_address     = r_addr;
    assign m_req_len               = r_len;
    assign m_data_queue_data_valid = (r_state == ARB_DATA) && w_grant_dvalid;
    assign m_data_queue_data       = w_grant_data;
    assign data_queue_pop          = ((r_state == ARB_DATA) && m_data_queue_pop) ? w_grant_oh : '0;
    assign m_resp_ready            = (r_state == ARB_DATA);
    assign resp_valid              = (r_state == ARB_RESP) ? w_grant_oh : '0;
    assign grant_id                = r_grant_id;
    assign busy                    = (r_state != ARB_IDLE);
    assign err_unexp_resp          = r_err;

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ARB_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (m_resp_valid && (r_state != ARB_DATA)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_any) begin
                        r_grant_id <= w_pick_idx;
                        r_addr     <= w_pick_addr;
                        r_len      <= w_pick_len;
                        r_state    <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (m_req_ready) begin
                        r_state <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (m_resp_valid) begin
                        r_state <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (w_grant_resp_ready) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Bench for axi_write_arbiter: plays clients and write master, checks against a round-robin model.
`timescale 1ns/1ps
module tb_axi_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 34;
    localparam int LW = 8;
    localparam int DW = 512;
    localparam int IW = 2;

    logic            core_clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    req_valid, req_ready, data_queue_pop, data_queue_data_valid;
    logic [N-1:0]    resp_valid, resp_ready;
    logic [N*AW-1:0] req_start_address;
    logic [N*LW-1:0] req_len;
    logic [N*DW-1:0] data_queue_data;
    logic            m_req_valid, m_req_ready, m_data_queue_pop, m_data_queue_data_valid;
    logic            m_resp_valid, m_resp_ready, busy, err_unexp_resp;
    logic [AW-1:0]   m_req_start_address;
    logic [LW-1:0]   m_req_len;
    logic [DW-1:0]   m_data_queue_data;
    logic [IW-1:0]   grant_id;

    logic [AW-1:0]   cl_addr [N];
    logic [LW-1:0]   cl_len  [N];
    logic [DW-1:0]   cl_data [N];

    int total = 0;
    int bad   = 0;
    int mdl_ptr;
    int last_grant;
    bit mdl_err;

    axi_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) dut (
        .core_clk(core_clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_start_address(req_start_address), .req_len(req_len),
        .data_queue_pop(data_queue_pop), .data_queue_data_valid(data_queue_data_valid),
        .data_queue_data(data_queue_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_start_address(m_req_start_address), .m_req_len(m_req_len),
        .m_data_queue_pop(m_data_queue_pop), .m_data_queue_data_valid(m_data_queue_data_valid),
        .m_data_queue_data(m_data_queue_data),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
        .grant_id(grant_id), .busy(busy), .err_unexp_resp(err_unexp_resp)
    );

    always #5 core_clk = ~core_clk;

    always_comb begin
        req_start_address = '0;
        req_len           = '0;
        data_queue_data   = '0;
        for (int i = 0; i < N; i++) begin
            req_start_address[i*AW +: AW] = cl_addr[i];
            req_len[i*LW +: LW]           = cl_len[i];
            data_queue_data[i*DW +: DW]   = cl_data[i];
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand512();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference arbitration: first pending client at or after the pointer, wrapping.
    function automatic int mdl_pick(input logic [N-1:0] pend, input int ptr);
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) begin
            t = pend >> ((ptr + k) % N);
            if (t[0]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_ready"}, DW'(req_ready), '0);
        chk({tag, "_pop"}, DW'(data_queue_pop), '0);
        chk({tag, "_resp_valid"}, DW'(resp_valid), '0);
        chk({tag, "_m_req_valid"}, DW'(m_req_valid), '0);
        chk({tag, "_m_dvalid"}, DW'(m_data_queue_data_valid), '0);
        chk({tag, "_m_resp_ready"}, DW'(m_resp_ready), '0);
        chk({tag, "_busy"}, DW'(busy), '0);
        chk({tag, "_grant_id"}, DW'(grant_id), '0);
        chk({tag, "_err"}, DW'(err_unexp_resp), '0);
        chk({tag, "_m_addr"}, DW'(m_req_start_address), '0);
        chk({tag, "_m_len"}, DW'(m_req_len), '0);
    endtask

    // One complete transaction, entered with the DUT idle just after a clock edge.
    task automatic do_txn(input int stall_at, input int stall_len, input int mreq_wait,
                          input int resp_wait, input logic [N-1:0] late_req);
        int c, nb, head, stall_left;
        logic [N-1:0]  oh;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_len;
        logic [DW-1:0] beats[$];
        c = mdl_pick(req_valid, mdl_ptr);
        if (c < 0) return;
        oh       = N'(1) << c;
        exp_addr = cl_addr[c];
        exp_len  = cl_len[c];
        nb       = int'(exp_len) + 1;
        for (int b = 0; b < nb; b++) beats.push_back(rand512());

        @(negedge core_clk);
        resp_ready = '0;
        #1;
        chk("idle_req_ready", DW'(req_ready), DW'(oh));
        chk("idle_busy", DW'(busy), '0);
        chk("idle_m_req_valid", DW'(m_req_valid), '0);
        chk("idle_grant_id", DW'(grant_id), DW'(last_grant));
        chk("idle_err", DW'(err_unexp_resp), DW'(mdl_err));
        @(posedge core_clk);

        for (int w = 0; w <= mreq_wait; w++) begin
            @(negedge core_clk);
            req_valid   = req_valid & ~oh;
            m_req_ready = (w == mreq_wait);
            #1;
            chk("req_m_req_valid", DW'(m_req_valid), 1);
            chk("req_addr", DW'(m_req_start_address), DW'(exp_addr));
            chk("req_len", DW'(m_req_len), DW'(exp_len));
            chk("req_grant_id", DW'(grant_id), DW'(c));
            chk("req_req_ready", DW'(req_ready), '0);
            chk("req_busy", DW'(busy), 1);
            @(posedge core_clk);
        end

        head       = 0;
        stall_left = stall_len;
        while (head < nb) begin
            @(negedge core_clk);
            m_req_ready = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (i != c) begin
                    data_queue_data_valid[i] = 1'($urandom);
                    cl_data[i] = rand512();
                end
            end
            if (head == stall_at && stall_left > 0) begin
                data_queue_data_valid[c] = 1'b0;
                cl_data[c]       = rand512();
                m_data_queue_pop = 1'b0;
                stall_left--;
            end else begin
                data_queue_data_valid[c] = 1'b1;
                cl_data[c]       = beats[head];
                m_data_queue_pop = 1'b1;
            end
            #1;
            chk("data_m_dvalid", DW'(m_data_queue_data_valid), DW'(m_data_queue_pop));
            if (m_data_queue_pop) chk("data_beat", m_data_queue_data, beats[head]);
            chk("data_pop", DW'(data_queue_pop), m_data_queue_pop ? DW'(oh) : '0);
            chk("data_m_resp_ready", DW'(m_resp_ready), 1);
            chk("data_m_req_valid", DW'(m_req_valid), '0);
            @(posedge core_clk);
            if (m_data_queue_pop) head++;
        end

        @(negedge core_clk);
        m_data_queue_pop      = 1'b0;
        data_queue_data_valid = '0;
        m_resp_valid          = 1'b1;
        #1;
        chk("bresp_m_resp_ready", DW'(m_resp_ready), 1);
        chk("bresp_resp_valid", DW'(resp_valid), '0);
        @(posedge core_clk);

        for (int w = 0; w <= resp_wait; w++) begin
            @(negedge core_clk);
            m_resp_valid          = 1'b0;
            req_valid             = req_valid | late_req;
            data_queue_data_valid = N'($urandom);
            resp_ready            = ((w == resp_wait) ? oh : '0) | (N'($urandom) & ~oh);
            #1;
            chk("resp_resp_valid", DW'(resp_valid), DW'(oh));
            chk("resp_req_ready", DW'(req_ready), '0);
            chk("resp_m_dvalid", DW'(m_data_queue_data_valid), '0);
            chk("resp_m_resp_ready", DW'(m_resp_ready), '0);
            chk("resp_busy", DW'(busy), 1);
            @(posedge core_clk);
        end
        data_queue_data_valid = '0;
        last_grant = c;
        mdl_ptr    = (c + 1) % N;
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] pend;
        int len;
        resetn = 1'b0;
        req_valid = '0; data_queue_data_valid = '0; resp_ready = '0;
        m_req_ready = 1'b0; m_data_queue_pop = 1'b0; m_resp_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            cl_addr[i] = '0; cl_len[i] = '0; cl_data[i] = '0;
        end
        mdl_ptr = 0; last_grant = 0; mdl_err = 0;

        repeat (2) @(negedge core_clk);
        #1;
        chk_quiet("reset");
        @(negedge core_clk);
        resetn = 1'b1;
        @(posedge core_clk);
        #1;

        // Unexpected B response while idle
        @(negedge core_clk);
        m_resp_valid = 1'b1;
        #1;
        chk("unexp_m_resp_ready", DW'(m_resp_ready), '0);
        chk("unexp_err_before", DW'(err_unexp_resp), '0);
        @(posedge core_clk);
        @(negedge core_clk);
        m_resp_valid = 1'b0;
        mdl_err = 1;
        #1;
        chk("unexp_err_after", DW'(err_unexp_resp), 1);
        chk("unexp_busy", DW'(busy), '0);
        chk("unexp_resp_valid", DW'(resp_valid), '0);
        @(posedge core_clk);
        #1;

        // Single request from client 2
        cl_addr[2] = 34'h1_0000_0000;
        cl_len[2]  = 8'd3;
        req_valid  = 4'b0100;
        do_txn(-1, 0, 0, 0, '0);

        // Client 1 stalls its data mid-burst
        cl_addr[1] = 34'h0_1234_5600;
        cl_len[1]  = 8'd5;
        req_valid  = 4'b0110;
        do_txn(2, 5, 1, 0, '0);
        do_txn(-1, 0, 0, 0, '0);

        // Response backpressure on client 0 while client 3 requests
        cl_addr[0] = 34'h2_0000_0040;
        cl_len[0]  = 8'd1;
        cl_addr[3] = 34'h3_FFFF_FFC0;
        cl_len[3]  = 8'd0;
        req_valid  = 4'b0001;
        do_txn(-1, 0, 0, 10, 4'b1000);
        do_txn(-1, 0, 2, 0, '0);

        // Reset in the middle of a burst
        req_valid = 4'b0100;
        @(posedge core_clk);
        @(negedge core_clk);
        m_req_ready = 1'b1;
        @(posedge core_clk);
        @(negedge core_clk);
        m_req_ready = 1'b0;
        data_queue_data_valid = 4'b0100;
        m_data_queue_pop = 1'b1;
        #1;
        chk("rst_pre_pop", DW'(data_queue_pop), DW'(4'b0100));
        @(posedge core_clk);
        @(negedge core_clk);
        resetn = 1'b0;
        #1;
        chk_quiet("midrst");
        @(negedge core_clk);
        resetn = 1'b1;
        m_data_queue_pop = 1'b0;
        data_queue_data_valid = '0;
        req_valid = '0;
        mdl_ptr = 0; last_grant = 0; mdl_err = 0;
        @(posedge core_clk);
        #1;

        // All clients request single beats; each winner re-requests at once
        for (int i = 0; i < N; i++) cl_len[i] = 8'd0;
        req_valid = 4'b1111;
        for (int t = 0; t < 2*N; t++) begin
            chk("allreq_order", DW'(mdl_pick(req_valid, mdl_ptr)), DW'(t % N));
            do_txn(-1, 0, 0, 0, '0);
            req_valid = req_valid | (N'(1) << last_grant);
        end
        req_valid = '0;

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    cl_addr[i]   = AW'({$urandom, $urandom});
                    cl_len[i]    = LW'($urandom_range(0, 3));
                    req_valid[i] = 1'b1;
                end
            end
            if (req_valid == '0) begin
                pend = N'(1) << $urandom_range(0, N-1);
                req_valid = pend;
            end
            len = $urandom_range(0, 3);
            do_txn(len, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
                   N'($urandom) & ~req_valid);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
